// File: rtl/mac_seq_pkg.sv
// Shared constants, state encoding and helpers for the MAC feed sequencer.
package mac_seq_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned DW     = 8;
    localparam int unsigned OUT_W  = 19;
    localparam int unsigned CNT_W  = 8;
    // Wide enough for 255 max-magnitude results, so the sum can never wrap.
    localparam int unsigned ACC_W  = OUT_W + CNT_W;
    localparam int unsigned ATOM_W = LANES * DW;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUTPUT
    } seq_state_e;

    // Sign-extend one mac_unit result to accumulator width.
    function automatic logic [ACC_W-1:0] sext_out(input logic [OUT_W-1:0] v);
        return {{(ACC_W - OUT_W){v[OUT_W-1]}}, v};
    endfunction

endpackage

// File: rtl/mac_seq_acc.sv
// Signed job accumulator: sums mac_unit results, counts them, and flags
// the addend that completes the job.
module mac_seq_acc
    import mac_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [OUT_W-1:0] data_i,
    input  logic [CNT_W-1:0] len_i,
    output logic [ACC_W-1:0] acc_o,
    output logic [CNT_W-1:0] recv_cnt_o,
    output logic             done_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so recv+1 == 256 cannot alias to 0.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    // Next-state: clear wins over add; done marks the final addend of the job.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        done_o = 1'b0;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            acc_d  = acc_q + sext_out(data_i);
            cnt_d  = cnt_inc[CNT_W-1:0];
            done_o = (cnt_inc == {1'b0, len_i});
        end
    end

    // Accumulator and receive-count state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o      = acc_q;
    assign recv_cnt_o = cnt_q;

endmodule

// File: rtl/mac_feed_sequencer.sv
// Feeds one job of paired data/weight atomics into mac_unit, sums the
// returned results and hands the job total back on a valid/ready port.
module mac_feed_sequencer
    import mac_seq_pkg::*;
(
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic [LANES-1:0]  cmd_nz_mask,
    input  logic              dat_in_valid,
    output logic              dat_in_ready,
    input  logic [ATOM_W-1:0] dat_in_data,
    input  logic              wt_in_valid,
    output logic              wt_in_ready,
    input  logic [ATOM_W-1:0] wt_in_data,
    output logic [ATOM_W-1:0] mac_dat_actv_data,
    output logic [LANES-1:0]  mac_dat_actv_nz,
    output logic [LANES-1:0]  mac_dat_actv_pvld,
    output logic [ATOM_W-1:0] mac_wt_actv_data,
    output logic [LANES-1:0]  mac_wt_actv_nz,
    output logic [LANES-1:0]  mac_wt_actv_pvld,
    input  logic [OUT_W-1:0]  mac_out_data,
    input  logic              mac_out_pvld,
    output logic              acc_out_valid,
    input  logic              acc_out_ready,
    output logic [ACC_W-1:0]  acc_out_data,
    output logic              busy,
    output logic              err_spurious
);

    seq_state_e        state_q;
    logic [CNT_W-1:0]  len_q;
    logic [LANES-1:0]  mask_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic              issue_q;
    logic [ATOM_W-1:0] dat_q;
    logic [ATOM_W-1:0] wt_q;
    logic              err_q;

    logic              fire;
    logic              collecting;
    logic              res_ok;
    logic              err_set;
    logic              acc_clr;
    logic              acc_done;
    logic [CNT_W:0]    issue_inc;
    logic [CNT_W-1:0]  recv_cnt;
    logic [ACC_W-1:0]  acc;

    // Both streams are consumed together; one stream alone never moves.
    assign fire         = (state_q == ISSUE) & dat_in_valid & wt_in_valid;
    assign dat_in_ready = fire;
    assign wt_in_ready  = fire;

    assign issue_inc  = {1'b0, issue_cnt_q} + (CNT_W + 1)'(1);
    assign collecting = (state_q == ISSUE) || (state_q == DRAIN);
    // A result is only legal while a matching atomic is still outstanding.
    assign res_ok     = mac_out_pvld & collecting & (recv_cnt < issue_cnt_q);
    assign err_set    = mac_out_pvld & ~res_ok;
    assign acc_clr    = (state_q == IDLE) & cmd_valid;

    mac_seq_acc u_acc (
        .clk_i      (nvdla_core_clk),
        .rst_i      (nvdla_core_rst),
        .clr_i      (acc_clr),
        .add_i      (res_ok),
        .data_i     (mac_out_data),
        .len_i      (len_q),
        .acc_o      (acc),
        .recv_cnt_o (recv_cnt),
        .done_o     (acc_done)
    );

    // Job FSM, issue registers and sticky error flag.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            mask_q      <= '0;
            issue_cnt_q <= '0;
            issue_q     <= 1'b0;
            dat_q       <= '0;
            wt_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            issue_q <= fire;
            if (fire) begin
                dat_q       <= dat_in_data;
                wt_q        <= wt_in_data;
                issue_cnt_q <= issue_inc[CNT_W-1:0];
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        len_q       <= cmd_len;
                        mask_q      <= cmd_nz_mask;
                        issue_cnt_q <= '0;
                        state_q     <= (cmd_len == '0) ? OUTPUT : ISSUE;
                    end
                end
                ISSUE: begin
                    if (fire && (issue_inc == {1'b0, len_q})) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (acc_done) begin
                        state_q <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (acc_out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mac_dat_actv_data = dat_q;
    assign mac_wt_actv_data  = wt_q;
    assign mac_dat_actv_pvld = {LANES{issue_q}};
    assign mac_wt_actv_pvld  = {LANES{issue_q}};
    assign mac_dat_actv_nz   = mask_q & {LANES{issue_q}};
    assign mac_wt_actv_nz    = mask_q & {LANES{issue_q}};

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign acc_out_valid = (state_q == OUTPUT);
    assign acc_out_data  = acc;
    assign err_spurious  = err_q;

endmodule

// File: tb/tb_mac_feed_sequencer.sv
// Scoreboard bench for mac_feed_sequencer with a behavioural mac_unit model.
module tb_mac_feed_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_len = '0;
    logic [7:0]  cmd_nz_mask = '0;
    logic        dat_in_valid = 1'b0;
    logic        dat_in_ready;
    logic [63:0] dat_in_data = '0;
    logic        wt_in_valid = 1'b0;
    logic        wt_in_ready;
    logic [63:0] wt_in_data = '0;
    logic [63:0] mac_dat_actv_data, mac_wt_actv_data;
    logic [7:0]  mac_dat_actv_nz, mac_wt_actv_nz;
    logic [7:0]  mac_dat_actv_pvld, mac_wt_actv_pvld;
    logic [18:0] mac_out_data = '0;
    logic        mac_out_pvld = 1'b0;
    logic        acc_out_valid;
    logic        acc_out_ready = 1'b0;
    logic [26:0] acc_out_data;
    logic        busy;
    logic        err_spurious;

    mac_feed_sequencer dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rst    (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_len           (cmd_len),
        .cmd_nz_mask       (cmd_nz_mask),
        .dat_in_valid      (dat_in_valid),
        .dat_in_ready      (dat_in_ready),
        .dat_in_data       (dat_in_data),
        .wt_in_valid       (wt_in_valid),
        .wt_in_ready       (wt_in_ready),
        .wt_in_data        (wt_in_data),
        .mac_dat_actv_data (mac_dat_actv_data),
        .mac_dat_actv_nz   (mac_dat_actv_nz),
        .mac_dat_actv_pvld (mac_dat_actv_pvld),
        .mac_wt_actv_data  (mac_wt_actv_data),
        .mac_wt_actv_nz    (mac_wt_actv_nz),
        .mac_wt_actv_pvld  (mac_wt_actv_pvld),
        .mac_out_data      (mac_out_data),
        .mac_out_pvld      (mac_out_pvld),
        .acc_out_valid     (acc_out_valid),
        .acc_out_ready     (acc_out_ready),
        .acc_out_data      (acc_out_data),
        .busy              (busy),
        .err_spurious      (err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [63:0] w;
        logic [7:0]  m;
    } atom_t;

    atom_t       exp_atom_q[$];
    logic [18:0] res_q[$];
    logic [26:0] exp_acc_q[$];

    logic [63:0]        dat_w[256];
    logic [63:0]        wt_w[256];
    logic signed [18:0] res_arr[256];

    int n_vec = 0;
    int n_err = 0;
    int mac_lat = 2;
    int pvld_total = 0;
    int inj_req = 0;
    int inj_done = 0;
    bit err_exp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // mac_unit model: checks each issued atomic and returns its result after mac_lat cycles.
    logic        pv[4] = '{default: 1'b0};
    logic [18:0] pd[4] = '{default: '0};
    atom_t       cur_a;
    always begin
        @(negedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) pv[i] = 1'b0;
            mac_out_pvld = 1'b0;
            mac_out_data = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                pv[i] = pv[i+1];
                pd[i] = pd[i+1];
            end
            pv[3] = 1'b0;
            if (mac_dat_actv_pvld != 0 || mac_wt_actv_pvld != 0) begin
                pvld_total++;
                if (exp_atom_q.size() == 0) begin
                    chk("mac_pvld_unexpected", 64'(mac_dat_actv_pvld), 64'd0);
                end else begin
                    cur_a = exp_atom_q.pop_front();
                    chk("mac_pvld", 64'({mac_dat_actv_pvld, mac_wt_actv_pvld}), 64'hFFFF);
                    chk("mac_nz", 64'({mac_dat_actv_nz, mac_wt_actv_nz}), 64'({cur_a.m, cur_a.m}));
                    chk("mac_dat_data", mac_dat_actv_data, cur_a.d);
                    chk("mac_wt_data", mac_wt_actv_data, cur_a.w);
                    pv[mac_lat-1] = 1'b1;
                    pd[mac_lat-1] = res_q.pop_front();
                end
            end
            mac_out_pvld = pv[0];
            mac_out_data = pd[0];
            if (inj_req != inj_done) begin
                inj_done     = inj_req;
                mac_out_pvld = 1'b1;
                mac_out_data = 19'd100;
            end
        end
    end

    // Result monitor: every accepted acc_out beat must match the oldest expected job sum.
    logic [26:0] exp_acc;
    always begin
        @(negedge clk);
        #2;
        if (!rst && acc_out_valid && acc_out_ready) begin
            if (exp_acc_q.size() == 0) begin
                chk("acc_out_unexpected", 64'(acc_out_valid), 64'd0);
            end else begin
                exp_acc = exp_acc_q.pop_front();
                chk("acc_out_data", 64'(acc_out_data), 64'(exp_acc));
            end
        end
    end

    task automatic check_rst(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_ctl"}, 64'({busy, acc_out_valid, err_spurious, dat_in_ready, wt_in_ready}),
            64'd0);
        chk({tag, "_mac_ctl"}, 64'({mac_dat_actv_pvld, mac_wt_actv_pvld, mac_dat_actv_nz,
            mac_wt_actv_nz}), 64'd0);
        chk({tag, "_mac_dat"}, mac_dat_actv_data, 64'd0);
        chk({tag, "_mac_wt"}, mac_wt_actv_data, 64'd0);
        chk({tag, "_acc"}, 64'(acc_out_data), 64'd0);
    endtask

    // One complete job; results come from res_arr[0..len-1].
    task automatic run_job(input int len, input logic [7:0] mask, input int lat,
                           input int wt_hold, input int gap_pct, input int out_hold,
                           input bit inject);
        longint      sum = 0;
        int          base;
        int          t;
        logic [26:0] e27;
        mac_lat = lat;
        for (int i = 0; i < len; i++) begin
            dat_w[i] = {$urandom, $urandom};
            wt_w[i]  = {$urandom, $urandom};
            exp_atom_q.push_back('{d: dat_w[i], w: wt_w[i], m: mask});
            res_q.push_back(res_arr[i]);
            sum += longint'(res_arr[i]);
        end
        e27 = sum[26:0];
        exp_acc_q.push_back(e27);
        base = pvld_total;

        cmd_valid   = 1'b1;
        cmd_len     = 8'(len);
        cmd_nz_mask = mask;
        #1;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_len     = 8'($urandom);
        cmd_nz_mask = 8'($urandom);
        #1;
        chk("busy_after_cmd", 64'({busy, cmd_ready}), 64'b10);
        if (len == 0) chk("len0_valid_next", 64'(acc_out_valid), 64'd1);
        @(negedge clk);

        fork
            begin : dat_drv
                int  td;
                bit  got;
                for (int i = 0; i < len; i++) begin
                    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                        dat_in_valid = 1'b0;
                        #1;
                        chk("rdy_low_dat_gap", 64'({dat_in_ready, wt_in_ready}), 64'd0);
                        @(negedge clk);
                    end
                    dat_in_valid = 1'b1;
                    dat_in_data  = dat_w[i];
                    td = 0;
                    do begin
                        #1;
                        got = dat_in_ready;
                        @(negedge clk);
                        td++;
                    end while (!got && td < 2000);
                    if (!got) chk("dat_fire_timeout", 64'(dat_in_ready), 64'd1);
                end
                dat_in_valid = 1'b0;
            end
            begin : wt_drv
                int  tw;
                bit  got;
                for (int h = 0; h < wt_hold; h++) begin
                    wt_in_valid = 1'b0;
                    #1;
                    chk("rdy_low_wt_hold", 64'({dat_in_ready, wt_in_ready}), 64'd0);
                    @(negedge clk);
                end
                for (int i = 0; i < len; i++) begin
                    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                        wt_in_valid = 1'b0;
                        #1;
                        chk("rdy_low_wt_gap", 64'({dat_in_ready, wt_in_ready}), 64'd0);
                        @(negedge clk);
                    end
                    wt_in_valid = 1'b1;
                    wt_in_data  = wt_w[i];
                    tw = 0;
                    do begin
                        #1;
                        got = wt_in_ready;
                        @(negedge clk);
                        tw++;
                    end while (!got && tw < 2000);
                    if (!got) chk("wt_fire_timeout", 64'(wt_in_ready), 64'd1);
                end
                wt_in_valid = 1'b0;
            end
        join

        #1;
        t = 0;
        while (!acc_out_valid && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!acc_out_valid) chk("acc_valid_timeout", 64'(acc_out_valid), 64'd1);

        for (int i = 0; i < out_hold; i++) begin
            chk("hold_valid_cmd_ready", 64'({acc_out_valid, cmd_ready}), 64'b10);
            chk("hold_acc_data", 64'(acc_out_data), 64'(e27));
            if (inject && i == 2) inj_req++;
            @(negedge clk);
            #1;
        end
        if (inject) err_exp = 1'b1;
        chk("err_spurious", 64'(err_spurious), 64'(err_exp));

        acc_out_ready = 1'b1;
        @(negedge clk);
        acc_out_ready = 1'b0;
        #1;
        chk("idle_after_hs", 64'({busy, cmd_ready, acc_out_valid}), 64'b010);
        chk("pvld_count", 64'(pvld_total - base), 64'(len));
        chk("acc_q_drained", 64'(exp_acc_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_rst("rst_held");
        rst = 1'b0;
        @(negedge clk);

        // Basic job: results 1..4 with latency 2.
        for (int i = 0; i < 4; i++) res_arr[i] = 19'(i + 1);
        run_job(4, 8'hFF, 2, 0, 0, 0, 1'b0);

        // Empty job.
        run_job(0, 8'hA5, 2, 0, 0, 0, 1'b0);

        // Weight stream withheld, negative total.
        res_arr[0] = -19'sd5;
        res_arr[1] = 19'sd2;
        res_arr[2] = -19'sd1;
        run_job(3, 8'h3C, 2, 5, 0, 0, 1'b0);

        // Longest job of max-positive results.
        for (int i = 0; i < 255; i++) res_arr[i] = 19'h3FFFF;
        run_job(255, 8'hFF, 3, 0, 0, 0, 1'b0);

        // Randomised jobs.
        for (int j = 0; j < 8; j++) begin
            int len;
            len = $urandom_range(24, 0);
            for (int i = 0; i < len; i++) res_arr[i] = 19'($urandom);
            run_job(len, 8'($urandom), $urandom_range(3, 1), $urandom_range(2, 0), 30,
                    $urandom_range(3, 0), 1'b0);
        end

        // Output held off, stray result injected while waiting.
        for (int i = 0; i < 5; i++) res_arr[i] = 19'($urandom);
        run_job(5, 8'h0F, 2, 0, 0, 10, 1'b1);

        // Reset in the middle of issuing a 6-atomic job.
        mac_lat = 2;
        for (int i = 0; i < 6; i++) begin
            dat_w[i] = {$urandom, $urandom};
            wt_w[i]  = {$urandom, $urandom};
            exp_atom_q.push_back('{d: dat_w[i], w: wt_w[i], m: 8'hFF});
            res_q.push_back(19'd9);
        end
        cmd_valid   = 1'b1;
        cmd_len     = 8'd6;
        cmd_nz_mask = 8'hFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dat_in_valid = 1'b1;
            wt_in_valid  = 1'b1;
            dat_in_data  = dat_w[i];
            wt_in_data   = wt_w[i];
            #1;
            chk("fire_before_rst", 64'({dat_in_ready, wt_in_ready}), 64'b11);
            @(negedge clk);
        end
        dat_in_valid = 1'b0;
        wt_in_valid  = 1'b0;
        rst = 1'b1;
        #1;
        check_rst("rst_mid_issue");
        exp_atom_q.delete();
        res_q.delete();
        err_exp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_rst("rst_released");
        @(negedge clk);

        // Fresh job after the abandoned one.
        res_arr[0] = 19'sd7;
        run_job(1, 8'h81, 2, 0, 0, 0, 1'b0);

        repeat (5) @(negedge clk);
        #1;
        chk("err_clear_final", 64'(err_spurious), 64'd0);
        chk("atoms_consumed", 64'(exp_atom_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_feed_sequencer.md
Name: mac_feed_sequencer

Overview:
- Sequences one 8-lane MAC atomic stream into mac_unit.
- Accepts a job command giving the number of atomics and the lane non-zero mask.
- Pairs data and weight words from two valid/ready requester streams and drives the mac_unit activation inputs.
- Counts mac_unit results, sums them into one accumulator, and returns that value on a valid/ready output before taking the next job.

Parameters:
- LANES, 8, MAC lanes per atomic.
- DW, 8, bits per lane element.
- OUT_W, 19, mac_unit result width, signed two's complement.
- CNT_W, 8, atomic-count width.
- ACC_W, 27, accumulator width; equals OUT_W+CNT_W, so it never overflows.

Ports:
- nvdla_core_clk  in  1  sole clock, rising edge.
- nvdla_core_rst  in  1  reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  job accept; high only in IDLE.
- cmd_len  in  CNT_W  atomics in the job, 0..255.
- cmd_nz_mask  in  LANES  lane enable mask for the job.
- dat_in_valid / dat_in_ready  in/out  1  data stream handshake.
- dat_in_data  in  LANES*DW  data atomic.
- wt_in_valid / wt_in_ready  in/out  1  weight stream handshake.
- wt_in_data  in  LANES*DW  weight atomic.
- mac_dat_actv_data / mac_wt_actv_data  out  LANES*DW  to mac_unit.
- mac_dat_actv_nz / mac_wt_actv_nz  out  LANES  to mac_unit.
- mac_dat_actv_pvld / mac_wt_actv_pvld  out  LANES  to mac_unit.
- mac_out_data  in  OUT_W  from mac_unit.
- mac_out_pvld  in  1  from mac_unit.
- acc_out_valid / acc_out_ready  out/in  1  result handshake.
- acc_out_data  out  ACC_W  signed job sum.
- busy  out  1  high whenever state is not IDLE.
- err_spurious  out  1  sticky error flag.

Behaviour:
- Reset and clock: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0 except cmd_ready=1. The FSM is in IDLE, counters and accumulator are 0. Reset mid-job abandons the job with no output.
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE:
  - On cmd_valid, latch len and mask, clear issue_cnt, recv_cnt and acc.
  - Go to ISSUE if len>0, else to OUTPUT with acc=0.
- ISSUE:
  - dat_in_ready = wt_in_ready = dat_in_valid & wt_in_valid. Both streams are consumed in the same cycle, never one alone.
  - Each such fire registers both data words and raises issue_q for exactly one cycle; issue_cnt increments.
  - When issue_cnt reaches len on a fire, go to DRAIN.
- mac_unit drive (all registered, 1 cycle after the fire):
  - mac_*_actv_pvld = {LANES{issue_q}}.
  - mac_*_actv_nz = mask & {LANES{issue_q}}.
  - Data registers hold their last value when not issuing.
- Result collection (ISSUE and DRAIN):
  - Each mac_out_pvld adds sign-extended mac_out_data into acc and increments recv_cnt.
  - Results may arrive while still issuing; the count is latency-independent.
- DRAIN:
  - Ready signals are low.
  - Go to OUTPUT in the same cycle mac_out_pvld brings recv_cnt to len; the final addend is included in acc.
- OUTPUT:
  - acc_out_valid=1 and acc_out_data=acc, held stable until acc_out_ready.
  - On handshake, go to IDLE; cmd_ready rises the next cycle.
- err_spurious: set when mac_out_pvld arrives in IDLE or OUTPUT, or when recv_cnt would exceed issue_cnt. The stray result is ignored. Only reset clears the flag.
- Throughput: one atomic per cycle when both input streams stay valid. Each job adds 2 cycles overhead plus mac_unit latency.
- cmd_valid outside IDLE has no effect.

Decomposition:
- Shared package mac_seq_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, OUTPUT};
  - constants LANES, DW, OUT_W, CNT_W, ACC_W;
  - localparam for the atomic bus width LANES*DW.
- One natural sub-module, mac_seq_acc: signed accumulator with clear, add-enable, recv counter and done compare.
- FSM and issue logic stay in the top.

Test Plan:
- Single job, len=4, mask=8'hFF, both streams always valid, mac_unit model latency 2, results 1,2,3,4 → four pvld pulses, acc_out_data=10, busy low 1 cycle after acc_out_ready.
- len=0 → no pvld pulse on mac outputs, acc_out_valid next cycle with acc_out_data=0.
- len=3, weight valid withheld 5 cycles, results -5,+2,-1 → no ready while wt_in_valid=0, acc_out_data=27'h7FFFFFC (-4).
- len=255, all results 19'h3FFFF (max positive) → acc_out_data=255*262143=66846465, no wrap.
- acc_out_ready held low 10 cycles → acc_out_valid and acc_out_data stable, cmd_ready low throughout; mac_out_pvld injected in OUTPUT sets err_spurious=1 and acc unchanged.
- Reset asserted mid-ISSUE after 2 of 6 atomics → all outputs at reset values immediately; a new job with len=1 and result 7 then returns 7.
